// File: rtl/sum_frame_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_frame_accumulator
// Purpose  : Accumulates COUNT adder sums per frame and hands the frame total
//            (with a sticky wrap flag) downstream over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module sum_frame_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic [DATA_W:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int                CNT_W    = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(COUNT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               w_beat;
    logic [ACC_W:0]     w_sum_ext;

    // Input is only offered while accumulating; DONE stalls upstream.
    assign in_ready  = (state_q == S_ACCUM) && en;
    assign w_beat    = in_valid && in_ready;

    // Top bit of the widened add is the wrap carry for this beat.
    assign w_sum_ext = {1'b0, acc_q} + {{(ACC_W - DATA_W){1'b0}}, in_data};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            state_d     = S_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_sum_d   = '0;
            out_ovf_d   = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_d = S_ACCUM;
                    end
                end

                S_ACCUM: begin
                    if (w_beat) begin
                        acc_d = w_sum_ext[ACC_W-1:0];
                        ovf_d = ovf_q | w_sum_ext[ACC_W];
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == LAST_CNT) begin
                            out_sum_d   = w_sum_ext[ACC_W-1:0];
                            out_ovf_d   = ovf_q | w_sum_ext[ACC_W];
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // out_sum/out_ovf stay as last presented until the next frame ends.
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = en ? S_ACCUM : S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_frame_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_frame_accumulator
// Purpose  : Vector table, directed corner sequences and random stimulus
//            against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_frame_accumulator;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 10;
    localparam int COUNT  = 4;
    localparam int MODW   = 1 << ACC_W;

    logic              clk = 1'b0;
    logic              rst, en, clear, in_valid, out_ready;
    logic [DATA_W:0]   in_data;
    logic              in_ready, out_ovf, out_valid;
    logic [ACC_W-1:0]  out_sum;

    int checks = 0;
    int errors = 0;

    // Frame-level model: mode 0=idle 1=collecting 2=holding a result.
    int  m_mode;
    int  m_q[$];
    int  m_sum;
    bit  m_ovf;
    bit  m_vld;
    logic last_rdy;

    typedef struct {
        bit rst; bit en; bit clr; int data; bit vld; bit ordy;
        bit e_rdy; bit e_vld; int e_sum; bit e_ovf;
    } vec_t;
    vec_t tbl[22];

    sum_frame_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0;
        m_q.delete();
        m_sum  = 0;
        m_ovf  = 1'b0;
        m_vld  = 1'b0;
    endfunction

    function automatic void model_update(input bit r, input bit e, input bit c,
                                         input int d, input bit v, input bit o);
        int total;
        if (r || c) begin
            model_reset();
        end else begin
            case (m_mode)
                0: if (e) m_mode = 1;
                1: if (e && v) begin
                    m_q.push_back(d);
                    if (m_q.size() == COUNT) begin
                        total = 0;
                        foreach (m_q[i]) total += m_q[i];
                        m_sum  = total % MODW;
                        m_ovf  = (total >= MODW);
                        m_vld  = 1'b1;
                        m_mode = 2;
                    end
                end
                default: if (o) begin
                    m_vld = 1'b0;
                    m_q.delete();
                    m_mode = e ? 1 : 0;
                end
            endcase
        end
    endfunction

    // Called just after a rising edge; drives one cycle and checks both sides of the edge.
    task automatic step(input bit r, input bit e, input bit c, input int d,
                        input bit v, input bit o);
        rst = r; en = e; clear = c; in_data = d[DATA_W:0]; in_valid = v; out_ready = o;
        #1;
        last_rdy = in_ready;
        chk("in_ready", in_ready, 32'((m_mode == 1) && e));
        model_update(r, e, c, int'(d[DATA_W:0]), v, o);
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, 32'(m_vld));
        chk("out_sum",   out_sum,   32'(m_sum));
        chk("out_ovf",   out_ovf,   32'(m_ovf));
    endtask

    initial begin
        // Full frame, stall in DONE, wrap frame, clear mid-frame, return to idle.
        tbl[0]  = '{0,1,0,  0,0,0, 0,0,   0,0};
        tbl[1]  = '{0,1,0, 10,1,0, 1,0,   0,0};
        tbl[2]  = '{0,1,0, 20,1,0, 1,0,   0,0};
        tbl[3]  = '{0,1,0, 30,1,0, 1,0,   0,0};
        tbl[4]  = '{0,1,0, 40,1,0, 1,1, 100,0};
        tbl[5]  = '{0,1,0, 99,1,0, 0,1, 100,0};
        tbl[6]  = '{0,1,0, 99,1,1, 0,0, 100,0};
        tbl[7]  = '{0,1,0,511,1,0, 1,0, 100,0};
        tbl[8]  = '{0,1,0,511,1,0, 1,0, 100,0};
        tbl[9]  = '{0,1,0,511,1,0, 1,0, 100,0};
        tbl[10] = '{0,1,0,511,1,0, 1,1,1020,1};
        tbl[11] = '{0,1,0,  0,0,1, 0,0,1020,1};
        tbl[12] = '{0,1,0,  7,1,0, 1,0,1020,1};
        tbl[13] = '{0,1,0,  9,1,0, 1,0,1020,1};
        tbl[14] = '{0,1,1,  5,1,0, 1,0,   0,0};
        tbl[15] = '{0,1,0, 50,1,0, 0,0,   0,0};
        tbl[16] = '{0,1,0,  1,1,0, 1,0,   0,0};
        tbl[17] = '{0,1,0,  2,1,0, 1,0,   0,0};
        tbl[18] = '{0,1,0,  3,1,0, 1,0,   0,0};
        tbl[19] = '{0,1,0,  4,1,0, 1,1,  10,0};
        tbl[20] = '{0,0,0,  0,0,1, 0,0,  10,0};
        tbl[21] = '{0,0,0,  0,1,0, 0,0,  10,0};

        rst = 1'b1; en = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_out_valid", out_valid, 32'd0);
        chk("reset_out_sum",   out_sum,   32'd0);
        chk("reset_out_ovf",   out_ovf,   32'd0);
        chk("reset_in_ready",  in_ready,  32'd0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].data, tbl[i].vld, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i),  last_rdy,  32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_out_valid", i), out_valid, 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_out_sum", i),   out_sum,   32'(tbl[i].e_sum));
            chk($sformatf("tbl%0d_out_ovf", i),   out_ovf,   32'(tbl[i].e_ovf));
        end

        // Backpressure: result held for 5 stalled cycles, stalled data never counted.
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 100, 1, 0);
        chk("t3_total", out_sum, 32'd400);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 200, 1, 0);
        chk("t3_held", out_sum, 32'd400);
        step(0, 1, 0, 200, 1, 1);
        for (int k = 1; k <= 4; k++) step(0, 1, 0, 1, 1, 0);
        chk("t3_next_sum", out_sum, 32'd4);
        chk("t3_next_vld", out_valid, 32'd1);
        step(0, 1, 0, 0, 0, 1);

        // Gaps in valid and enable: only handshaked beats count.
        step(0, 1, 0, 5, 1, 0);
        step(0, 1, 0, 5, 0, 0);
        step(0, 1, 0, 5, 0, 0);
        step(0, 1, 0, 5, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 5, 1, 0);
        step(0, 1, 0, 5, 1, 0);
        chk("t4_not_yet", out_valid, 32'd0);
        step(0, 1, 0, 5, 1, 0);
        chk("t4_vld", out_valid, 32'd1);
        chk("t4_sum", out_sum, 32'd20);
        step(0, 0, 0, 0, 0, 1);

        // Reset while holding a result, then reset mid-frame.
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 300, 1, 0);
        chk("t6_pre_vld", out_valid, 32'd1);
        step(1, 1, 0, 0, 0, 0);
        chk("t6_done_vld", out_valid, 32'd0);
        chk("t6_done_sum", out_sum, 32'd0);
        step(0, 0, 0, 3, 1, 0);
        chk("t6_idle_rdy", last_rdy, 32'd0);
        step(0, 1, 0, 3, 1, 0);
        step(0, 1, 0, 3, 1, 0);
        step(0, 1, 0, 3, 1, 0);
        step(1, 1, 0, 3, 1, 0);
        step(0, 1, 0, 3, 1, 0);
        chk("t6_accum_rdy", last_rdy, 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 800; k++) begin
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 59) == 0),
                 int'($urandom_range(0, 511)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
